// File: rtl/tt_pkg.sv
// Shared types and defaults for the truth-table sweeper: FSM encoding, table size, golden word.
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } tt_state_t;

   localparam int              TT_N_INPUTS       = 3;
   localparam int              ROWS              = 2**TT_N_INPUTS;
   localparam logic [ROWS-1:0] TT_GOLDEN_DEFAULT = 8'h35;

endpackage

// File: rtl/truth_table_sweeper.sv
// Drives every input vector 0..2**N-1 to a combinational block, samples f after SETTLE_CYCLES, checks vs EXPECTED.
// Sweep takes 2**N*(SETTLE_CYCLES+1) cycles from start to done; start ignored while busy, abort cancels.
module truth_table_sweeper
   import tt_pkg::*;
#(
   parameter int                    N_INPUTS      = TT_N_INPUTS,
   parameter int                    SETTLE_CYCLES = 2,
   parameter logic [2**N_INPUTS-1:0] EXPECTED     = TT_GOLDEN_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   output logic [N_INPUTS-1:0]      x_out,
   input  logic                     f_in,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [2**N_INPUTS-1:0]   captured,
   output logic [2**N_INPUTS-1:0]   mismatch
);

   localparam int                   NROWS       = 2**N_INPUTS;
   localparam int                   CW          = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0]        SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [N_INPUTS-1:0]  LAST_ROW    = '1;

   tt_state_t               r_state;
   logic [CW-1:0]           r_settle_cnt;
   logic [N_INPUTS-1:0]     r_x;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_pass;
   logic [NROWS-1:0]        r_captured;
   logic [NROWS-1:0]        r_mismatch;
   logic [NROWS-1:0]        w_cap_next;

   // Table as it will look once the current row is stored; lets pass/mismatch land with done.
   always_comb begin
      w_cap_next        = r_captured;
      w_cap_next[r_x]   = f_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_settle_cnt <= '0;
         r_x          <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_captured   <= '0;
         r_mismatch   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !abort) begin
                  r_state      <= SETTLE;
                  r_x          <= '0;
                  r_settle_cnt <= '0;
                  r_captured   <= '0;
                  r_pass       <= 1'b0;
                  r_mismatch   <= '0;
                  r_busy       <= 1'b1;
               end
            end
            SETTLE: begin
               if (abort) begin
                  r_state      <= IDLE;
                  r_x          <= '0;
                  r_settle_cnt <= '0;
                  r_busy       <= 1'b0;
                  r_pass       <= 1'b0;
                  r_mismatch   <= '0;
               end else if (r_settle_cnt == SETTLE_LAST) begin
                  r_settle_cnt <= '0;
                  r_state      <= SAMPLE;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 1'b1;
               end
            end
            SAMPLE: begin
               if (abort) begin
                  // Row under test is discarded; earlier rows stay visible for debug.
                  r_state      <= IDLE;
                  r_x          <= '0;
                  r_settle_cnt <= '0;
                  r_busy       <= 1'b0;
                  r_pass       <= 1'b0;
                  r_mismatch   <= '0;
               end else begin
                  r_captured <= w_cap_next;
                  if (r_x == LAST_ROW) begin
                     r_state    <= DONE;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_pass     <= (w_cap_next == EXPECTED);
                     r_mismatch <= w_cap_next ^ EXPECTED;
                  end else begin
                     r_x     <= r_x + 1'b1;
                     r_state <= SETTLE;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign x_out    = r_x;
   assign busy     = r_busy;
   assign done     = r_done;
   assign pass     = r_pass;
   assign captured = r_captured;
   assign mismatch = r_mismatch;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: golden/faulty tables, abort, ignored starts, settle noise, short settle, async reset.
module tb_truth_table_sweeper;

   logic       clk;
   logic       rst_n;
   logic       start, abort, f_in, f_inv;
   logic [2:0] x_out;
   logic       busy, done, pass;
   logic [7:0] captured, mismatch;
   logic [7:0] tt;

   logic       start1, abort1, f_in1;
   logic [2:0] x_out1;
   logic       busy1, done1, pass1;
   logic [7:0] captured1, mismatch1;
   logic [7:0] tt1;

   int checks = 0;
   int errors = 0;
   int edges;
   int n;
   int dcount;

   // Behavioural model of the block under measurement.
   assign f_in  = tt[x_out] ^ f_inv;
   assign f_in1 = tt1[x_out1];

   truth_table_sweeper u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .x_out(x_out), .f_in(f_in), .busy(busy), .done(done),
      .pass(pass), .captured(captured), .mismatch(mismatch)
   );

   truth_table_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
      .x_out(x_out1), .f_in(f_in1), .busy(busy1), .done(done1),
      .pass(pass1), .captured(captured1), .mismatch(mismatch1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulses start, then counts edges until done; f_inv corrupts f_in in non-SAMPLE cycles when noisy.
   task run_sweep(input int mid_at, input bit noisy, output int e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e     = 0;
      f_inv = noisy;
      while (done !== 1'b1 && e < 100) begin
         @(negedge clk);
         e++;
         start = (e == mid_at);
         f_inv = noisy && ((e % 3) != 2);
      end
      start = 1'b0;
      f_inv = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; f_inv = 1'b0; tt = 8'h35;
      start1 = 1'b0; abort1 = 1'b0; tt1 = 8'h35;
      #1;
      chk("rst_x_out", x_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_captured", captured, 0);
      chk("rst_mismatch", mismatch, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Golden table
      tt = 8'h35;
      run_sweep(-1, 1'b0, edges);
      chk("gold_edges", edges, 24);
      chk("gold_done", done, 1);
      chk("gold_busy", busy, 0);
      chk("gold_captured", captured, 8'h35);
      chk("gold_pass", pass, 1);
      chk("gold_mismatch", mismatch, 8'h00);
      @(negedge clk);
      chk("gold_done_pulse", done, 0);
      chk("gold_x_hold", x_out, 7);
      chk("gold_pass_hold", pass, 1);

      // f stuck at 0
      tt = 8'h00;
      run_sweep(-1, 1'b0, edges);
      chk("stuck_edges", edges, 24);
      chk("stuck_captured", captured, 8'h00);
      chk("stuck_mismatch", mismatch, 8'h35);
      chk("stuck_pass", pass, 0);
      @(negedge clk);

      // Row 6 flipped
      tt = 8'h75;
      run_sweep(-1, 1'b0, edges);
      chk("flip6_captured", captured, 8'h75);
      chk("flip6_mismatch", mismatch, 8'h40);
      chk("flip6_pass", pass, 0);
      @(negedge clk);

      // Settle-time noise plus a start mid-sweep
      tt = 8'h35;
      run_sweep(10, 1'b1, edges);
      chk("noise_edges", edges, 24);
      chk("noise_captured", captured, 8'h35);
      chk("noise_pass", pass, 1);
      // start during the DONE cycle
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("donestart_busy", busy, 0);
      chk("donestart_done", done, 0);
      @(negedge clk);
      chk("donestart_busy2", busy, 0);
      chk("donestart_x", x_out, 7);

      // Abort while row 3 is settling
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (x_out !== 3'd3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reach_row3", x_out, 3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_x", x_out, 0);
      chk("abort_pass", pass, 0);
      chk("abort_mismatch", mismatch, 0);
      chk("abort_captured", captured, 8'h05);
      dcount = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) dcount++;
      end
      chk("abort_no_done", dcount, 0);
      chk("abort_idle_busy", busy, 0);

      // abort and start together
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abst_busy", busy, 0);
      repeat (5) @(negedge clk);
      chk("abst_busy_later", busy, 0);
      chk("abst_x", x_out, 0);

      // SETTLE_CYCLES = 1 instance
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      edges  = 0;
      while (done1 !== 1'b1 && edges < 100) begin
         @(negedge clk);
         edges++;
      end
      chk("s1_edges", edges, 16);
      chk("s1_captured", captured1, 8'h35);
      chk("s1_pass", pass1, 1);
      chk("s1_mismatch", mismatch1, 8'h00);

      // Async reset mid-sweep
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_x", x_out, 0);
      chk("mrst_captured", captured, 0);
      chk("mrst_done", done, 0);
      chk("mrst_pass", pass, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1) dcount++;
      end
      chk("mrst_no_done", dcount, 0);
      chk("mrst_idle_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
